rsa_run_ctrl: RTL and testbench
===============================

Name: rsa_run_ctrl

Overview:
Run sequencer and data-memory arbiter for the pipelined RSA CPU core. It lets a host load operands (key, modulus, message) into data memory while the core is held in reset, then releases and starts the core. It detects the program's halt-store, drains the pipeline and hands memory back so the host can read the result. It sits between the core's data-memory port, the host port and the single-port data memory.

Parameters:
HALT_ADDR, 32'h0000_00FC, byte address whose store by the core signals program end
RESET_CYCLES, 4, cycles cpu_reset is held high in BOOT (>=1)
DRAIN_CYCLES, 4, cycles the core keeps running after the halt-store (>=1)
MAX_CYCLES, 32'd1_000_000, RUN-cycle limit before forced stop

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
host_go  in  1  pulse: start a run (accepted only in IDLE or DONE)
host_we  in  1  host write strobe
host_addr  in  32  host byte address
host_wdata  in  32  host write data
host_rdata  out  32  read data to host
host_ready  out  1  1 = host owns memory
cpu_reset  out  1  reset to core
cpu_start  out  1  start/enable to core
cpu_memwrite  in  1  core MemWrite
cpu_addr  in  32  core ALUResult (data address)
cpu_wdata  in  32  core WriteData
cpu_rdata  out  32  ReadData to core
mem_we  out  1  data-memory write enable
mem_addr  out  32  data-memory address
mem_wdata  out  32  data-memory write data
mem_rdata  in  32  data-memory read data (combinational read)
busy  out  1  BOOT, RUN or DRAIN
done  out  1  run finished, held until next host_go
timeout  out  1  last run ended by MAX_CYCLES
cycle_count  out  32  RUN+DRAIN cycles of last/current run

Behaviour:
- FSM states: IDLE, BOOT, RUN, DRAIN, DONE. Reset -> IDLE from any state, including mid-run; in-flight core store is dropped.
- Reset values: state=IDLE, cpu_reset=1, cpu_start=0, host_ready=1, busy=0, done=0, timeout=0, cycle_count=0, both counters 0.
- Ownership is decided by registered state only (no comb path from inputs to owner select). Host owns memory in IDLE, DONE and BOOT. Core owns it in RUN and DRAIN.
- Host owns: mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata, host_rdata=mem_rdata, cpu_rdata=0.
- Core owns: mem_we=cpu_memwrite, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_rdata=mem_rdata, host_rdata=0. host_we is ignored (no write reaches memory).
- host_ready=1 in IDLE, BOOT, DONE. host_ready=0 in RUN, DRAIN.
- IDLE: cpu_reset=1, cpu_start=0. On host_go -> BOOT, clear done, timeout and cycle_count, set boot counter to 0.
- BOOT: cpu_reset=1, cpu_start=0. Boot counter increments each cycle. After RESET_CYCLES cycles in BOOT -> RUN.
- RUN: cpu_reset=0, cpu_start=1, cycle_count increments every cycle.
  - Halt: cpu_memwrite=1 && cpu_addr==HALT_ADDR (exact 32-bit compare). The halt-store itself is written to memory (status word). Next state DRAIN, drain counter=0.
  - Timeout: cycle_count reaches MAX_CYCLES-1 while counting with no halt this cycle -> DONE, timeout=1.
  - Halt and timeout in the same cycle: halt wins, timeout=0.
- DRAIN: cpu_reset=0, cpu_start=1, core keeps memory so pipelined stores complete. cycle_count keeps incrementing. Further HALT_ADDR stores are ordinary writes. After DRAIN_CYCLES cycles -> DONE.
- DONE: cpu_reset=1, cpu_start=0, done=1. cycle_count and timeout are frozen. host_go -> BOOT, which starts a new run and clears status.
- host_go is ignored in BOOT, RUN and DRAIN.
- busy=1 exactly in BOOT, RUN, DRAIN.
- cycle_count saturates at 32'hFFFF_FFFF and never wraps.
- Latency: host_go sampled at cycle N -> BOOT at N+1 -> first cpu_start=1 at N+1+RESET_CYCLES.

Test Plan:
- Host load: in IDLE, write 0x1234_5678 to 0x10, then read 0x10 -> host_rdata=0x1234_5678, cpu_reset=1, busy=0.
- Normal run with defaults: host_go at cycle 0 -> cpu_start rises at cycle 5. Core stores 0x1 to 0xFC at RUN cycle 20 -> DRAIN, mem_we=1 that cycle. done=1 after 4 drain cycles, cycle_count=24, timeout=0, host reads 0xFC = 0x1.
- Host write during RUN (host_we=1, addr 0x10, data 0xDEAD) -> mem_we follows core only; 0x10 unchanged after DONE; host_ready=0 throughout RUN and DRAIN.
- Timeout with MAX_CYCLES=50 and no halt-store -> DONE after 50 RUN cycles, timeout=1, cycle_count=50, cpu_reset=1.
- Halt on the timeout cycle (MAX_CYCLES=50, halt-store at RUN cycle 49) -> DRAIN, then DONE with timeout=0.
- reset asserted mid-RUN -> next cycle IDLE, cpu_reset=1, done=0, cycle_count=0. host_go asserted during DRAIN is ignored. host_go in DONE starts a new run and clears done.

Source files
------------

// File: rtl/rsa_run_ctrl.sv
// ============================================================================
// Module   : rsa_run_ctrl
// Brief    : Run sequencer and data-memory arbiter for the pipelined RSA core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rsa_run_ctrl #(
    parameter logic [31:0] HALT_ADDR    = 32'h0000_00FC,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [31:0] MAX_CYCLES   = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_go,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_ready,
    output logic        cpu_reset,
    output logic        cpu_start,
    input  logic        cpu_memwrite,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BOOT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] C_BOOT_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] C_DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
    localparam logic [31:0] C_MAX_LAST   = MAX_CYCLES - 32'd1;
    localparam logic [31:0] C_CNT_SAT    = 32'hFFFF_FFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_boot_cnt;
    logic [31:0] w_boot_cnt_nxt;
    logic [31:0] r_drain_cnt;
    logic [31:0] w_drain_cnt_nxt;
    logic [31:0] r_cycle_count;
    logic [31:0] w_cycle_count_nxt;
    logic [31:0] w_cycle_inc;
    logic        r_timeout;
    logic        w_timeout_nxt;
    logic        w_halt;

    assign w_halt      = cpu_memwrite && (cpu_addr == HALT_ADDR);
    assign w_cycle_inc = (r_cycle_count == C_CNT_SAT) ? r_cycle_count
                                                      : r_cycle_count + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_boot_cnt    <= '0;
            r_drain_cnt   <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_boot_cnt    <= w_boot_cnt_nxt;
            r_drain_cnt   <= w_drain_cnt_nxt;
            r_cycle_count <= w_cycle_count_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_boot_cnt_nxt    = r_boot_cnt;
        w_drain_cnt_nxt   = r_drain_cnt;
        w_cycle_count_nxt = r_cycle_count;
        w_timeout_nxt     = r_timeout;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (host_go) begin
                    w_state_nxt       = S_BOOT;
                    w_boot_cnt_nxt    = '0;
                    w_cycle_count_nxt = '0;
                    w_timeout_nxt     = 1'b0;
                end
            end
            S_BOOT: begin
                if (r_boot_cnt == C_BOOT_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_boot_cnt_nxt = r_boot_cnt + 32'd1;
                end
            end
            S_RUN: begin
                w_cycle_count_nxt = w_cycle_inc;
                // A halt-store on the final allowed cycle still ends the run cleanly.
                if (w_halt) begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = '0;
                end else if (r_cycle_count == C_MAX_LAST) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                w_cycle_count_nxt = w_cycle_inc;
                if (r_drain_cnt == C_DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Memory owner is a pure function of the registered state.
    always_comb begin
        cpu_reset  = 1'b1;
        cpu_start  = 1'b0;
        host_ready = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        mem_we     = host_we;
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
        host_rdata = mem_rdata;
        cpu_rdata  = '0;
        case (r_state)
            S_BOOT: begin
                busy = 1'b1;
            end
            S_RUN, S_DRAIN: begin
                cpu_reset  = 1'b0;
                cpu_start  = 1'b1;
                host_ready = 1'b0;
                busy       = 1'b1;
                mem_we     = cpu_memwrite;
                mem_addr   = cpu_addr;
                mem_wdata  = cpu_wdata;
                host_rdata = '0;
                cpu_rdata  = mem_rdata;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_rsa_run_ctrl.sv
// ============================================================================
// Module   : tb_rsa_run_ctrl
// Brief    : Timestamp-based run model with per-cycle compare and directed runs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rsa_run_ctrl;

    localparam int R    = 4;
    localparam int D    = 4;
    localparam int MAXC = 50;
    localparam logic [31:0] HALT = 32'h0000_00FC;

    localparam int P_IDLE  = 0;
    localparam int P_BOOT  = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic        clk;
    logic        reset;
    logic        host_go;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_ready;
    logic        cpu_reset;
    logic        cpu_start;
    logic        cpu_memwrite;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;

    rsa_run_ctrl #(
        .MAX_CYCLES (32'd50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_go      (host_go),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .host_ready   (host_ready),
        .cpu_reset    (cpu_reset),
        .cpu_start    (cpu_start),
        .cpu_memwrite (cpu_memwrite),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port data memory driven by the arbiter.
    logic [31:0] ram [0:63] = '{default: '0};
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    end

    // Model: a run is described by when BOOT began, when the halt-store
    // happened and when DONE begins; everything else follows from the clock.
    int          cyc       = 0;
    bit          m_active  = 1'b0;
    bit          m_to      = 1'b0;
    int          m_t0      = 0;
    int          m_halt_at = -1;
    int          m_end     = -1;
    logic [31:0] exp_mem [0:63] = '{default: '0};
    bit          started   = 1'b0;
    int          n_checks  = 0;
    int          n_errors  = 0;

    function automatic int phase_at(int c);
        if (!m_active) return P_IDLE;
        if (m_end >= 0 && c >= m_end) return P_DONE;
        if (c < m_t0 + R) return P_BOOT;
        if (m_halt_at >= 0) return P_DRAIN;
        return P_RUN;
    endfunction

    function automatic bit host_side(int ph);
        return (ph == P_IDLE) || (ph == P_BOOT) || (ph == P_DONE);
    endfunction

    function automatic int count_at(int c, int ph);
        if (ph == P_RUN || ph == P_DRAIN) return c - (m_t0 + R);
        if (ph == P_DONE) return m_end - (m_t0 + R);
        return 0;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (host_side(phase_at(cyc))) begin
            if (host_we) exp_mem[host_addr[7:2]] <= host_wdata;
        end else if (cpu_memwrite) begin
            exp_mem[cpu_addr[7:2]] <= cpu_wdata;
        end
        if (reset) begin
            m_active <= 1'b0;
            m_to     <= 1'b0;
        end else begin
            case (phase_at(cyc))
                P_IDLE, P_DONE: begin
                    if (host_go) begin
                        m_active  <= 1'b1;
                        m_t0      <= cyc + 1;
                        m_halt_at <= -1;
                        m_end     <= -1;
                        m_to      <= 1'b0;
                    end
                end
                P_RUN: begin
                    if (cpu_memwrite && cpu_addr == HALT) begin
                        m_halt_at <= cyc;
                        m_end     <= cyc + 1 + D;
                    end else if (cyc - (m_t0 + R) + 1 == MAXC) begin
                        m_end <= cyc + 1;
                        m_to  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        int ph;
        bit hs;
        ph = phase_at(cyc);
        hs = host_side(ph);
        chk("cpu_reset",   32'(cpu_reset),  32'(hs));
        chk("cpu_start",   32'(cpu_start),  32'(!hs));
        chk("host_ready",  32'(host_ready), 32'(hs));
        chk("busy",        32'(busy),       32'(ph == P_BOOT || ph == P_RUN || ph == P_DRAIN));
        chk("done",        32'(done),       32'(ph == P_DONE));
        chk("timeout",     32'(timeout),    32'(m_to));
        chk("cycle_count", cycle_count,     32'(count_at(cyc, ph)));
        chk("mem_we",      32'(mem_we),     32'(hs ? host_we : cpu_memwrite));
        chk("mem_addr",    mem_addr,        hs ? host_addr : cpu_addr);
        chk("mem_wdata",   mem_wdata,       hs ? host_wdata : cpu_wdata);
        chk("host_rdata",  host_rdata,      hs ? exp_mem[host_addr[7:2]] : 32'd0);
        chk("cpu_rdata",   cpu_rdata,       hs ? 32'd0 : exp_mem[cpu_addr[7:2]]);
    endtask

    always @(negedge clk) begin
        if (started) check_cycle();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_memwrite = we;
        cpu_addr     = a;
        cpu_wdata    = d;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        host_go = 1'b0;
        host_we = 1'b0;
        host_addr = 32'h10;
        host_wdata = '0;
        cpu_drive(1'b0, 32'h10, '0);
        tick();
        started = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_count",     cycle_count,    32'd0);

        // Host load in IDLE
        host_we = 1'b1; host_addr = 32'h10; host_wdata = 32'h1234_5678;
        tick();
        host_we = 1'b0;
        chk("load_readback", host_rdata, 32'h1234_5678);
        chk("load_cpu_reset", 32'(cpu_reset), 32'd1);

        // Normal run, host hammering 0x10 while the core owns memory
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        n = 0;
        while (!cpu_start && n < 20) begin tick(); n++; end
        chk("start_latency", 32'(n), 32'd4);
        host_we = 1'b1; host_addr = 32'h10; host_wdata = 32'h0000_DEAD;
        for (int k = 0; k < 20; k++) begin
            if (k == 5)       cpu_drive(1'b1, 32'h20, 32'hAAAA_0005);
            else if (k == 19) cpu_drive(1'b1, HALT, 32'h1);
            else              cpu_drive(1'b0, 32'h10, 32'h0);
            #1;
            if (k == 19) chk("halt_mem_we", 32'(mem_we), 32'd1);
            tick();
        end
        for (int d = 0; d < D; d++) begin
            host_go = (d == 0);
            if (d == 0) cpu_drive(1'b1, 32'h24, 32'h0000_BEEF);
            else        cpu_drive(1'b0, 32'h10, 32'h0);
            tick();
        end
        host_go = 1'b0;
        host_we = 1'b0;
        cpu_drive(1'b0, 32'h10, 32'h0);
        chk("run_done",    32'(done),    32'd1);
        chk("run_count",   cycle_count,  32'd24);
        chk("run_timeout", 32'(timeout), 32'd0);
        host_addr = HALT;
        #1 chk("run_status", host_rdata, 32'h1);
        host_addr = 32'h10;
        #1 chk("run_0x10_kept", host_rdata, 32'h1234_5678);
        host_addr = 32'h24;
        #1 chk("run_drain_store", host_rdata, 32'h0000_BEEF);

        // Timeout run started from DONE
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        chk("restart_done",  32'(done), 32'd0);
        chk("restart_busy",  32'(busy), 32'd1);
        chk("restart_count", cycle_count, 32'd0);
        n = 0;
        while (!done && n < 200) begin tick(); n++; end
        chk("to_latency",   32'(n),        32'd54);
        chk("to_count",     cycle_count,   32'd50);
        chk("to_flag",      32'(timeout),  32'd1);
        chk("to_cpu_reset", 32'(cpu_reset), 32'd1);

        // Halt-store on the very cycle the limit is reached
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        n = 0;
        while (!cpu_start && n < 20) begin tick(); n++; end
        chk("co_start", 32'(n), 32'd4);
        repeat (MAXC - 1) tick();
        cpu_drive(1'b1, HALT, 32'h77);
        tick();
        cpu_drive(1'b1, HALT, 32'h99);
        tick();
        cpu_drive(1'b0, 32'h10, 32'h0);
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        chk("co_drain_len", 32'(n),       32'd3);
        chk("co_timeout",   32'(timeout), 32'd0);
        chk("co_count",     cycle_count,  32'd54);
        host_addr = HALT;
        #1 chk("co_status", host_rdata, 32'h99);

        // Reset in the middle of a run
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        n = 0;
        while (!cpu_start && n < 20) begin tick(); n++; end
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_done",      32'(done),      32'd0);
        chk("mid_count",     cycle_count,    32'd0);
        chk("mid_busy",      32'(busy),      32'd0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
